// File: rtl/seq_sched_pkg.sv
// Shared types and constants for the sequencer command scheduler.
//   sched_state_t : scheduler FSM states
//   SEQ_CMD_IDLE  : command ID the sequencer treats as "do nothing"
//   SEQ_LUT_W     : width of one sequencer LUT entry
package seq_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LUT_WR,
        ISSUE,
        RUN
    } sched_state_t;

    localparam logic [7:0] SEQ_CMD_IDLE = 8'h00;
    localparam int         SEQ_LUT_W    = 29;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and registered full/empty flags.
// Ports:
//   clk, reset      : clock and synchronous active-high reset
//   push, push_data : write request; ignored while full (even with a pop)
//   pop             : read request; ignored while empty
//   head            : entry at the read pointer (valid while !empty)
//   count           : number of stored entries (registered)
//   full, empty     : registered occupancy flags
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic [AW:0]      count_next;
    logic             full_reg;
    logic             empty_reg;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full_reg;
    assign do_pop  = pop && !empty_reg;

    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + (AW+1)'(1);
            2'b01:   count_next = count_reg - (AW+1)'(1);
            default: count_next = count_reg;
        endcase
    end

    // Storage has no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_next;
            full_reg  <= (count_next == (AW+1)'(DEPTH));
            empty_reg <= (count_next == '0);
        end
    end

    // Asynchronous head read; the consumer registers it before it leaves
    // the block, so the read still lands in a flop.
    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;
    assign full  = full_reg;
    assign empty = empty_reg;

endmodule

// File: rtl/seq_cmd_scheduler.sv
// Command scheduler and LUT-write arbiter in front of the sequencer.
// Host commands are queued and handed to the sequencer one at a time while it
// is idle; host LUT writes are slotted in between sequences and take priority
// over queued commands. A sticky flag records a sequencer that never started.
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o/cmd_id_i : host command queue input (ID 0 dropped)
//   lut_wr_valid_i/lut_wr_ready_o/lut_wr_data_i : host LUT write request,
//                                    ready is a one-cycle issue pulse
//   seq_command_id_o, seq_lut_*_o  : drive the sequencer command / LUT port
//   seq_busy_i, seq_done_i         : sequencer status
//   queue_count_o, active_o, done_count_o, timeout_err_o : status outputs
module seq_cmd_scheduler
    import seq_sched_pkg::*;
#(
    parameter int FIFO_DEPTH    = 8,
    parameter int CMD_W         = 8,
    parameter int LUT_W         = SEQ_LUT_W,
    parameter int START_TIMEOUT = 1024
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cmd_valid_i,
    output logic                        cmd_ready_o,
    input  logic [CMD_W-1:0]            cmd_id_i,
    input  logic                        lut_wr_valid_i,
    output logic                        lut_wr_ready_o,
    input  logic [LUT_W-1:0]            lut_wr_data_i,
    output logic [CMD_W-1:0]            seq_command_id_o,
    output logic                        seq_lut_access_en_o,
    output logic                        seq_lut_rw_mode_o,
    output logic [LUT_W-1:0]            seq_lut_write_data_o,
    input  logic                        seq_busy_i,
    input  logic                        seq_done_i,
    output logic [$clog2(FIFO_DEPTH):0] queue_count_o,
    output logic                        active_o,
    output logic [15:0]                 done_count_o,
    output logic                        timeout_err_o
);

    localparam int TW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

    sched_state_t state_reg, state_next;

    logic             fifo_push;
    logic             fifo_pop;
    logic [CMD_W-1:0] fifo_head;
    logic             fifo_full;
    logic             fifo_empty;

    logic [TW-1:0]    to_cnt_reg, to_cnt_next;
    logic             done_inc;
    logic             timeout_set;

    logic [CMD_W-1:0] seq_cmd_reg;
    logic             active_reg;
    logic             lut_wr_reg;
    logic [LUT_W-1:0] lut_data_reg;
    logic [15:0]      done_cnt_reg;
    logic             timeout_reg;

    // The idle command is acknowledged to the host but never queued.
    assign fifo_push = cmd_valid_i && !fifo_full &&
                       (cmd_id_i != CMD_W'(SEQ_CMD_IDLE));

    sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (cmd_id_i),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (queue_count_o),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_next  = state_reg;
        to_cnt_next = to_cnt_reg;
        fifo_pop    = 1'b0;
        done_inc    = 1'b0;
        timeout_set = 1'b0;
        case (state_reg)
            IDLE: begin
                // Counter is held at zero here so each ISSUE starts fresh.
                to_cnt_next = '0;
                if (lut_wr_valid_i && !seq_busy_i) begin
                    state_next = LUT_WR;
                end else if (!fifo_empty && !seq_busy_i) begin
                    state_next = ISSUE;
                end
            end
            LUT_WR: begin
                state_next = IDLE;
            end
            ISSUE: begin
                if (seq_busy_i) begin
                    fifo_pop   = 1'b1;
                    state_next = RUN;
                end else if (to_cnt_reg == TW'(START_TIMEOUT - 1)) begin
                    // Sequencer never picked it up: drop the command.
                    fifo_pop    = 1'b1;
                    timeout_set = 1'b1;
                    state_next  = IDLE;
                end else begin
                    to_cnt_next = to_cnt_reg + TW'(1);
                end
            end
            RUN: begin
                // RUN is only entered with busy high, so busy low here is
                // the falling edge; a coincident done pulse counts once.
                if (seq_done_i || !seq_busy_i) begin
                    done_inc   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the
    // state they describe rather than trailing it by a cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            to_cnt_reg   <= '0;
            seq_cmd_reg  <= '0;
            active_reg   <= 1'b0;
            lut_wr_reg   <= 1'b0;
            lut_data_reg <= '0;
            done_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            to_cnt_reg   <= to_cnt_next;
            seq_cmd_reg  <= (state_next == ISSUE) ? fifo_head : '0;
            active_reg   <= (state_next == ISSUE) || (state_next == RUN);
            lut_wr_reg   <= (state_next == LUT_WR);
            lut_data_reg <= (state_next == LUT_WR) ? lut_wr_data_i : '0;
            if (done_inc) begin
                done_cnt_reg <= done_cnt_reg + 16'd1;
            end
            if (timeout_set) begin
                timeout_reg <= 1'b1;
            end
        end
    end

    assign cmd_ready_o          = !fifo_full;
    assign seq_command_id_o     = seq_cmd_reg;
    assign active_o             = active_reg;
    assign seq_lut_access_en_o  = lut_wr_reg;
    assign seq_lut_rw_mode_o    = lut_wr_reg;
    assign lut_wr_ready_o       = lut_wr_reg;
    assign seq_lut_write_data_o = lut_data_reg;
    assign done_count_o         = done_cnt_reg;
    assign timeout_err_o        = timeout_reg;

endmodule

// File: tb/tb_seq_cmd_scheduler.sv
// Testbench for seq_cmd_scheduler: directed scenarios with exact cycle
// checks, then a randomized phase against a queue-based reference model
// with a behavioural sequencer responder.
module tb_seq_cmd_scheduler;

    localparam int FIFO_DEPTH    = 8;
    localparam int CMD_W         = 8;
    localparam int LUT_W         = 29;
    localparam int START_TIMEOUT = 16;
    localparam int CW            = $clog2(FIFO_DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid_i = 1'b0;
    logic             cmd_ready_o;
    logic [CMD_W-1:0] cmd_id_i = '0;
    logic             lut_wr_valid_i = 1'b0;
    logic             lut_wr_ready_o;
    logic [LUT_W-1:0] lut_wr_data_i = '0;
    logic [CMD_W-1:0] seq_command_id_o;
    logic             seq_lut_access_en_o;
    logic             seq_lut_rw_mode_o;
    logic [LUT_W-1:0] seq_lut_write_data_o;
    logic             seq_busy_i = 1'b0;
    logic             seq_done_i = 1'b0;
    logic [CW-1:0]    queue_count_o;
    logic             active_o;
    logic [15:0]      done_count_o;
    logic             timeout_err_o;

    int n_checks = 0;
    int n_fails  = 0;

    seq_cmd_scheduler #(
        .FIFO_DEPTH    (FIFO_DEPTH),
        .CMD_W         (CMD_W),
        .LUT_W         (LUT_W),
        .START_TIMEOUT (START_TIMEOUT)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .cmd_valid_i          (cmd_valid_i),
        .cmd_ready_o          (cmd_ready_o),
        .cmd_id_i             (cmd_id_i),
        .lut_wr_valid_i       (lut_wr_valid_i),
        .lut_wr_ready_o       (lut_wr_ready_o),
        .lut_wr_data_i        (lut_wr_data_i),
        .seq_command_id_o     (seq_command_id_o),
        .seq_lut_access_en_o  (seq_lut_access_en_o),
        .seq_lut_rw_mode_o    (seq_lut_rw_mode_o),
        .seq_lut_write_data_o (seq_lut_write_data_o),
        .seq_busy_i           (seq_busy_i),
        .seq_done_i           (seq_done_i),
        .queue_count_o        (queue_count_o),
        .active_o             (active_o),
        .done_count_o         (done_count_o),
        .timeout_err_o        (timeout_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        reset          = 1'b1;
        cmd_valid_i    = 1'b0;
        cmd_id_i       = '0;
        lut_wr_valid_i = 1'b0;
        lut_wr_data_i  = '0;
        seq_busy_i     = 1'b0;
        seq_done_i     = 1'b0;
        tick();
        check({tag, "_ready"},   cmd_ready_o, 1);
        check({tag, "_count"},   queue_count_o, 0);
        check({tag, "_cmd"},     seq_command_id_o, 0);
        check({tag, "_active"},  active_o, 0);
        check({tag, "_done"},    done_count_o, 0);
        check({tag, "_err"},     timeout_err_o, 0);
        check({tag, "_lut_en"},  seq_lut_access_en_o, 0);
        check({tag, "_lut_rw"},  seq_lut_rw_mode_o, 0);
        check({tag, "_lut_dat"}, seq_lut_write_data_o, 0);
        check({tag, "_lut_rdy"}, lut_wr_ready_o, 0);
        reset = 1'b0;
    endtask

    // Wait (bounded) for a command on the sequencer port, check it, then act
    // as the sequencer: busy for two cycles, completion by busy falling.
    task automatic serve_one(input string tag, input logic [CMD_W-1:0] exp_id);
        int w = 0;
        while (seq_command_id_o == '0 && w < 40) begin
            tick();
            w++;
        end
        check({tag, "_issue_id"}, seq_command_id_o, exp_id);
        $display("issue id=%02h (%s)", seq_command_id_o, tag);
        seq_busy_i = 1'b1;
        tick();
        tick();
        seq_busy_i = 1'b0;
        tick();
    endtask

    task automatic run_random(input int n_cycles);
        logic [CMD_W-1:0] mq[$];
        logic [CMD_W-1:0] p_id = '0;
        logic [CMD_W-1:0] p_cmd = '0;
        logic             p_valid = 1'b0;
        logic             p_busy = 1'b0;
        logic             p_done = 1'b0;
        logic             run_pending = 1'b0;
        logic             exp_err = 1'b0;
        logic [15:0]      exp_done = '0;
        int               wait_cnt = 0;
        logic             lut_pending = 1'b0;
        int               lut_age = 0;
        logic [LUT_W-1:0] lut_data_cur = '0;
        int               sq_state = 0;
        int               sq_delay = 0;
        int               sq_len = 0;
        logic             full_before;
        logic             timed_out;
        for (int cyc = 0; cyc < n_cycles; cyc++) begin
            tick();
            // Model update: previous cycle's inputs against previous outputs.
            if (run_pending && (p_done || !p_busy)) begin
                exp_done    = exp_done + 16'd1;
                run_pending = 1'b0;
            end
            full_before = (mq.size() == FIFO_DEPTH);
            timed_out   = 1'b0;
            if (p_cmd != '0) begin
                if (p_busy) begin
                    run_pending = 1'b1;
                    wait_cnt    = 0;
                    if (mq.size() == 0) check("rnd_pop_nonempty", mq.size(), 1);
                    else void'(mq.pop_front());
                end else begin
                    wait_cnt++;
                    if (wait_cnt == START_TIMEOUT) begin
                        timed_out = 1'b1;
                        exp_err   = 1'b1;
                        wait_cnt  = 0;
                        if (mq.size() == 0) check("rnd_drop_nonempty", mq.size(), 1);
                        else void'(mq.pop_front());
                    end
                end
            end else begin
                wait_cnt = 0;
            end
            if (p_valid && p_id != '0 && !full_before) mq.push_back(p_id);

            // Compare.
            check("rnd_count", queue_count_o, mq.size());
            check("rnd_ready", cmd_ready_o, (mq.size() != FIFO_DEPTH));
            check("rnd_done_count", done_count_o, exp_done);
            check("rnd_timeout_err", timeout_err_o, exp_err);
            if (timed_out) check("rnd_timeout_cmd", seq_command_id_o, 0);
            if (seq_command_id_o != '0 && p_cmd == '0) begin
                check("rnd_issue_id", seq_command_id_o, (mq.size() > 0) ? mq[0] : '0);
                $display("issue id=%02h cycle=%0d queued=%0d", seq_command_id_o, cyc, mq.size());
            end
            if (lut_wr_ready_o) begin
                check("rnd_lut_pending", lut_pending, 1);
                check("rnd_lut_en", seq_lut_access_en_o, 1);
                check("rnd_lut_rw", seq_lut_rw_mode_o, 1);
                check("rnd_lut_data", seq_lut_write_data_o, lut_data_cur);
                check("rnd_lut_seq_idle", p_busy, 0);
                $display("lut write data=%08h cycle=%0d", seq_lut_write_data_o, cyc);
                lut_pending    = 1'b0;
                lut_wr_valid_i = 1'b0;
            end else begin
                check("rnd_lut_en_idle", seq_lut_access_en_o, 0);
            end
            if (lut_pending) begin
                lut_age++;
                if (lut_age > 300) begin
                    check("rnd_lut_stall_cycles", lut_age, 0);
                    lut_pending    = 1'b0;
                    lut_wr_valid_i = 1'b0;
                end
            end

            // Behavioural sequencer.
            seq_done_i = 1'b0;
            if (sq_state == 0 && seq_command_id_o != '0) begin
                if ($urandom_range(0, 7) == 0) begin
                    sq_state = 3;
                end else begin
                    sq_delay = $urandom_range(0, 3);
                    sq_state = 1;
                end
            end
            if (sq_state == 1) begin
                if (sq_delay == 0) begin
                    seq_busy_i = 1'b1;
                    sq_len     = $urandom_range(2, 5);
                    sq_state   = 2;
                end else begin
                    sq_delay--;
                end
            end else if (sq_state == 2) begin
                sq_len--;
                if (sq_len == 0) begin
                    seq_busy_i = 1'b0;
                    seq_done_i = ($urandom_range(0, 1) == 1);
                    sq_state   = 0;
                end else if (sq_len == 1 && $urandom_range(0, 3) == 0) begin
                    seq_done_i = 1'b1;
                end
            end else if (sq_state == 3 && seq_command_id_o == '0) begin
                sq_state = 0;
            end

            // Host stimulus.
            cmd_valid_i = ($urandom_range(0, 1) == 1);
            cmd_id_i    = ($urandom_range(0, 7) == 0) ? '0 : CMD_W'($urandom_range(1, 255));
            if (!lut_pending && $urandom_range(0, 15) == 0) begin
                lut_pending    = 1'b1;
                lut_age        = 0;
                lut_data_cur   = LUT_W'($urandom());
                lut_wr_valid_i = 1'b1;
                lut_wr_data_i  = lut_data_cur;
            end

            p_valid = cmd_valid_i;
            p_id    = cmd_id_i;
            p_busy  = seq_busy_i;
            p_done  = seq_done_i;
            p_cmd   = seq_command_id_o;
        end
        cmd_valid_i    = 1'b0;
        lut_wr_valid_i = 1'b0;
        seq_busy_i     = 1'b0;
        seq_done_i     = 1'b0;
    endtask

    initial begin
        // ---- single command, exact latencies ----
        do_reset("rst0");
        cmd_valid_i = 1'b1;
        cmd_id_i    = 8'h01;
        tick();                                           // cycle 1
        cmd_valid_i = 1'b0;
        check("t1_count_c1", queue_count_o, 1);
        check("t1_cmd_c1", seq_command_id_o, 0);
        tick();                                           // cycle 2
        check("t1_cmd_c2", seq_command_id_o, 8'h01);
        check("t1_active_c2", active_o, 1);
        tick();
        tick();                                           // cycle 4
        check("t1_cmd_c4", seq_command_id_o, 8'h01);
        seq_busy_i = 1'b1;
        tick();                                           // cycle 5
        check("t1_cmd_c5", seq_command_id_o, 0);
        check("t1_active_c5", active_o, 1);
        check("t1_count_c5", queue_count_o, 0);
        repeat (5) tick();                                // cycle 10
        check("t1_active_c10", active_o, 1);
        check("t1_done_c10", done_count_o, 0);
        seq_done_i = 1'b1;
        tick();                                           // cycle 11
        seq_done_i = 1'b0;
        seq_busy_i = 1'b0;
        check("t1_done_c11", done_count_o, 1);
        check("t1_active_c11", active_o, 0);
        $display("single command done_count=%0d", done_count_o);

        // ---- queue full, FIFO order ----
        do_reset("rst1");
        seq_busy_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cmd_valid_i = 1'b1;
            cmd_id_i    = CMD_W'(16 + i);
            tick();
        end
        cmd_valid_i = 1'b0;
        check("t2_count_full", queue_count_o, 8);
        check("t2_ready_full", cmd_ready_o, 0);
        cmd_valid_i = 1'b1;
        cmd_id_i    = 8'h18;
        tick();
        cmd_valid_i = 1'b0;
        check("t2_count_9th", queue_count_o, 8);
        check("t2_ready_9th", cmd_ready_o, 0);
        tick();
        check("t2_no_issue_busy", seq_command_id_o, 0);
        check("t2_inactive_busy", active_o, 0);
        seq_busy_i = 1'b0;
        for (int i = 0; i < 8; i++) serve_one("t2", CMD_W'(16 + i));
        check("t2_done", done_count_o, 8);
        check("t2_count_empty", queue_count_o, 0);
        check("t2_ready_empty", cmd_ready_o, 1);

        // ---- LUT write priority and stall ----
        do_reset("rst2");
        cmd_valid_i = 1'b1;
        cmd_id_i    = 8'h02;
        tick();
        cmd_valid_i    = 1'b0;
        lut_wr_valid_i = 1'b1;
        lut_wr_data_i  = 29'd67375105;
        tick();
        check("t3_lut_en", seq_lut_access_en_o, 1);
        check("t3_lut_rw", seq_lut_rw_mode_o, 1);
        check("t3_lut_data", seq_lut_write_data_o, 29'd67375105);
        check("t3_lut_ready", lut_wr_ready_o, 1);
        check("t3_cmd_during_lut", seq_command_id_o, 0);
        $display("lut write data=%08h", seq_lut_write_data_o);
        lut_wr_valid_i = 1'b0;
        tick();
        check("t3_lut_en_after", seq_lut_access_en_o, 0);
        check("t3_lut_ready_after", lut_wr_ready_o, 0);
        check("t3_cmd_after_lut", seq_command_id_o, 0);
        tick();
        check("t3_cmd_issue", seq_command_id_o, 8'h02);
        serve_one("t3", 8'h02);
        seq_busy_i     = 1'b1;
        lut_wr_valid_i = 1'b1;
        lut_wr_data_i  = 29'h0ABC_DEF1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_stall_ready", lut_wr_ready_o, 0);
            check("t3_stall_en", seq_lut_access_en_o, 0);
        end
        seq_busy_i = 1'b0;
        tick();
        check("t3_late_ready", lut_wr_ready_o, 1);
        check("t3_late_data", seq_lut_write_data_o, 29'h0ABC_DEF1);
        $display("lut write data=%08h", seq_lut_write_data_o);
        lut_wr_valid_i = 1'b0;
        tick();
        check("t3_late_ready_pulse", lut_wr_ready_o, 0);

        // ---- start timeout ----
        do_reset("rst3");
        cmd_valid_i = 1'b1;
        cmd_id_i    = 8'h03;
        tick();
        cmd_id_i = 8'h04;
        tick();                                           // cycle 2
        cmd_valid_i = 1'b0;
        check("t4_cmd_c2", seq_command_id_o, 8'h03);
        repeat (START_TIMEOUT - 1) tick();                // last waiting cycle
        check("t4_cmd_held", seq_command_id_o, 8'h03);
        check("t4_err_before", timeout_err_o, 0);
        tick();
        check("t4_cmd_dropped", seq_command_id_o, 0);
        check("t4_err_set", timeout_err_o, 1);
        check("t4_count_after_drop", queue_count_o, 1);
        check("t4_active_after_drop", active_o, 0);
        tick();
        check("t4_next_issue", seq_command_id_o, 8'h04);
        serve_one("t4", 8'h04);
        check("t4_err_sticky", timeout_err_o, 1);
        check("t4_done", done_count_o, 1);

        // ---- idle command and reset mid-run ----
        do_reset("rst4");
        cmd_valid_i = 1'b1;
        cmd_id_i    = 8'h00;
        tick();
        cmd_valid_i = 1'b0;
        check("t5_noop_count", queue_count_o, 0);
        check("t5_noop_ready", cmd_ready_o, 1);
        tick();
        tick();
        check("t5_noop_cmd", seq_command_id_o, 0);
        cmd_valid_i = 1'b1;
        cmd_id_i    = 8'h05;
        tick();
        cmd_valid_i = 1'b0;
        tick();
        check("t5_issue", seq_command_id_o, 8'h05);
        seq_busy_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd_valid_i = 1'b1;
            cmd_id_i    = CMD_W'(6 + i);
            tick();
        end
        cmd_valid_i = 1'b0;
        check("t5_run_count", queue_count_o, 3);
        check("t5_run_active", active_o, 1);
        check("t5_run_cmd", seq_command_id_o, 0);
        do_reset("t5_rst");
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t5_post_rst_cmd", seq_command_id_o, 0);
            check("t5_post_rst_count", queue_count_o, 0);
        end

        // ---- randomized traffic ----
        do_reset("rst5");
        run_random(3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
